// File: rtl/ddr_pkg.sv
// ddr_pkg: shared state, grant and sizing definitions for the DDR burst scheduler
package ddr_pkg;
   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_WR   = 2'd1;
   localparam logic [1:0] S_RD   = 2'd2;
   typedef enum logic {GRANT_WR = 1'b0, GRANT_RD = 1'b1} grant_e;
   localparam int unsigned BURST_LEN_MAX = 512;
endpackage

// File: rtl/ring_ptr.sv
// ring_ptr: ring buffer pointer advancing by STEP and wrapping to 0 at WRAP
module ring_ptr #(
   parameter int W    = 25,
   parameter int STEP = 128,
   parameter int WRAP = 4096
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         i_clr,
   input  logic         i_adv,
   output logic [W-1:0] o_ptr
);
   logic [W-1:0] r_ptr;
   logic [W-1:0] w_sum;
   assign w_sum = r_ptr + W'(STEP);
   assign o_ptr = r_ptr;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_ptr <= '0;
      else if (i_clr) r_ptr <= '0;
      else if (i_adv) r_ptr <= (w_sum == W'(WRAP)) ? '0 : w_sum;
endmodule

// File: rtl/ddr_burst_sched.sv
// ddr_burst_sched: schedules fixed-length DDR write/read bursts over a ring buffer,
// round-robin between the AD fill side and the wavelet drain side.
module ddr_burst_sched
   import ddr_pkg::*;
#(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 25,
   parameter int BURST_LEN     = 128,
   parameter int RING_WORDS    = 4096,
   parameter int BASE_ADDR     = 0,
   parameter int FIFO_AW       = 10,
   parameter int WT_FIFO_DEPTH = 1024
) (
   input  logic                  mem_clk,
   input  logic                  rst_n,
   input  logic                  local_init_done,
   input  logic [FIFO_AW-1:0]    ad_fifo_usedw,
   input  logic                  ad_fifo_full,
   input  logic [FIFO_AW-1:0]    wt_fifo_wrusedw,
   output logic                  wr_burst_req,
   output logic [9:0]            wr_burst_len,
   output logic [ADDR_WIDTH-1:0] wr_burst_addr,
   input  logic                  wr_burst_finish,
   output logic                  rd_burst_req,
   output logic [9:0]            rd_burst_len,
   output logic [ADDR_WIDTH-1:0] rd_burst_addr,
   input  logic                  rd_burst_finish,
   output logic [ADDR_WIDTH-1:0] ring_fill,
   output logic                  overflow
);
   if (DATA_WIDTH < 1 || BURST_LEN < 1 || BURST_LEN > int'(BURST_LEN_MAX) || RING_WORDS % BURST_LEN != 0) begin : g_bad_cfg
      $error("ddr_burst_sched: illegal burst/ring configuration");
   end

   logic [1:0]            r_state;
   grant_e                r_last;
   logic [ADDR_WIDTH-1:0] r_fill;
   logic [ADDR_WIDTH-1:0] w_wptr;
   logic [ADDR_WIDTH-1:0] w_rptr;
   logic [31:0]           w_wt_free;
   logic                  w_we;
   logic                  w_re;
   logic                  w_gnt_wr;
   logic                  w_gnt_rd;
   logic                  w_wr_done;
   logic                  w_rd_done;

   assign w_wt_free = 32'(WT_FIFO_DEPTH) - 32'(wt_fifo_wrusedw);
   assign w_we      = 32'(ad_fifo_usedw) >= 32'(BURST_LEN) && r_fill <= ADDR_WIDTH'(RING_WORDS - BURST_LEN);
   assign w_re      = r_fill >= ADDR_WIDTH'(BURST_LEN) && w_wt_free >= 32'(BURST_LEN);
   // when both sides are eligible, the side not served last wins
   assign w_gnt_wr  = w_we && (!w_re || r_last == GRANT_RD);
   assign w_gnt_rd  = w_re && !w_gnt_wr;
   assign w_wr_done = r_state == S_WR && wr_burst_finish;
   assign w_rd_done = r_state == S_RD && rd_burst_finish;

   assign wr_burst_len = 10'(BURST_LEN);
   assign rd_burst_len = 10'(BURST_LEN);
   assign ring_fill    = r_fill;

   ring_ptr #(.W(ADDR_WIDTH), .STEP(BURST_LEN), .WRAP(RING_WORDS)) u_wptr (
      .clk(mem_clk), .rst_n(rst_n), .i_clr(!local_init_done), .i_adv(w_wr_done), .o_ptr(w_wptr)
   );
   ring_ptr #(.W(ADDR_WIDTH), .STEP(BURST_LEN), .WRAP(RING_WORDS)) u_rptr (
      .clk(mem_clk), .rst_n(rst_n), .i_clr(!local_init_done), .i_adv(w_rd_done), .o_ptr(w_rptr)
   );

   always_ff @(posedge mem_clk or negedge rst_n)
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_last        <= GRANT_RD;
         r_fill        <= '0;
         wr_burst_req  <= 1'b0;
         rd_burst_req  <= 1'b0;
         wr_burst_addr <= '0;
         rd_burst_addr <= '0;
      end else if (!local_init_done) begin
         r_state      <= S_IDLE;
         r_last       <= GRANT_RD;
         r_fill       <= '0;
         wr_burst_req <= 1'b0;
         rd_burst_req <= 1'b0;
      end else if (r_state == S_IDLE) begin
         if (w_gnt_wr) begin
            r_state       <= S_WR;
            r_last        <= GRANT_WR;
            wr_burst_addr <= ADDR_WIDTH'(BASE_ADDR) + w_wptr;
         end else if (w_gnt_rd) begin
            r_state       <= S_RD;
            r_last        <= GRANT_RD;
            rd_burst_addr <= ADDR_WIDTH'(BASE_ADDR) + w_rptr;
         end
      end else if (r_state == S_WR) begin
         wr_burst_req <= !wr_burst_finish;
         if (wr_burst_finish) begin
            r_state <= S_IDLE;
            r_fill  <= r_fill + ADDR_WIDTH'(BURST_LEN);
         end
      end else begin
         rd_burst_req <= !rd_burst_finish;
         if (rd_burst_finish) begin
            r_state <= S_IDLE;
            r_fill  <= r_fill - ADDR_WIDTH'(BURST_LEN);
         end
      end

   // sticky until reset; calibration loss deliberately leaves it set
   always_ff @(posedge mem_clk or negedge rst_n)
      if (!rst_n) overflow <= 1'b0;
      else if (ad_fifo_full && local_init_done) overflow <= 1'b1;
endmodule

// File: tb/tb_ddr_burst_sched.sv
// tb_ddr_burst_sched: directed checks of burst scheduling, ring wrap, round-robin,
// calibration abort and sticky overflow with hand-computed expectations.
module tb_ddr_burst_sched;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        init = 1'b0;
   logic [9:0]  usedw = 10'd200;
   logic        full = 1'b0;
   logic [9:0]  wrusedw = 10'd0;
   logic        wr_req, rd_req, wr_fin = 1'b0, rd_fin = 1'b0, ovf;
   logic [9:0]  wr_len, rd_len;
   logic [24:0] wr_addr, rd_addr, fill;
   int          total = 0;
   int          bad = 0;

   always #5 clk = ~clk;

   ddr_burst_sched #(
      .DATA_WIDTH(32), .ADDR_WIDTH(25), .BURST_LEN(128), .RING_WORDS(512),
      .BASE_ADDR(32'h1000), .FIFO_AW(10), .WT_FIFO_DEPTH(1024)
   ) dut (
      .mem_clk(clk), .rst_n(rst_n), .local_init_done(init),
      .ad_fifo_usedw(usedw), .ad_fifo_full(full), .wt_fifo_wrusedw(wrusedw),
      .wr_burst_req(wr_req), .wr_burst_len(wr_len), .wr_burst_addr(wr_addr), .wr_burst_finish(wr_fin),
      .rd_burst_req(rd_req), .rd_burst_len(rd_len), .rd_burst_addr(rd_addr), .rd_burst_finish(rd_fin),
      .ring_fill(fill), .overflow(ovf)
   );

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_req(input bit rd, input string tag);
      int n = 0;
      while (!(rd ? rd_req : wr_req) && n < 12) begin
         step();
         n++;
      end
      chk({tag, " req"}, 32'(rd ? rd_req : wr_req), 32'd1);
   endtask

   task automatic burst(input bit rd, input logic [24:0] ea, input string tag);
      wait_req(rd, tag);
      chk({tag, " addr"}, 32'(rd ? rd_addr : wr_addr), 32'(ea));
      chk({tag, " other req"}, 32'(rd ? wr_req : rd_req), 32'd0);
      if (rd) rd_fin = 1'b1;
      else wr_fin = 1'b1;
      step();
      rd_fin = 1'b0;
      wr_fin = 1'b0;
      chk({tag, " req drop"}, 32'(rd ? rd_req : wr_req), 32'd0);
   endtask

   initial begin
      int seen;
      #1;
      chk("rst wr_req", 32'(wr_req), 32'd0);
      chk("rst ovf", 32'(ovf), 32'd0);
      step();
      step();
      rst_n = 1'b1;
      chk("rst rd_req", 32'(rd_req), 32'd0);
      chk("rst fill", 32'(fill), 32'd0);
      chk("rst wr_addr", 32'(wr_addr), 32'd0);
      chk("rst rd_addr", 32'(rd_addr), 32'd0);
      chk("wr_len", 32'(wr_len), 32'd128);
      chk("rd_len", 32'(rd_len), 32'd128);
      step();
      step();
      step();
      chk("no req before init", 32'(wr_req), 32'd0);
      init = 1'b1;
      step();
      chk("grant edge req low", 32'(wr_req), 32'd0);
      step();
      chk("init wr_req", 32'(wr_req), 32'd1);
      chk("init wr_addr", 32'(wr_addr), 32'h1000);
      step();
      step();
      chk("wr_req held", 32'(wr_req), 32'd1);
      usedw = 10'd0;
      wr_fin = 1'b1;
      step();
      wr_fin = 1'b0;
      chk("wr done req", 32'(wr_req), 32'd0);
      chk("fill after wr", 32'(fill), 32'd128);
      step();
      chk("rd not yet", 32'(rd_req), 32'd0);
      burst(1'b1, 25'h1000, "first rd");
      chk("fill after rd", 32'(fill), 32'd0);

      init = 1'b0;
      step();
      init = 1'b1;
      usedw = 10'd1000;
      wrusedw = 10'd1023;
      burst(1'b0, 25'h1000, "ring wr0");
      burst(1'b0, 25'h1080, "ring wr1");
      burst(1'b0, 25'h1100, "ring wr2");
      burst(1'b0, 25'h1180, "ring wr3");
      chk("ring full fill", 32'(fill), 32'd512);
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (wr_req || rd_req) seen++;
      end
      chk("no 5th write", 32'(seen), 32'd0);

      usedw = 10'd0;
      wrusedw = 10'd0;
      burst(1'b1, 25'h1000, "drain rd0");
      burst(1'b1, 25'h1080, "drain rd1");
      chk("fill 256", 32'(fill), 32'd256);
      usedw = 10'd1000;
      burst(1'b0, 25'h1000, "rr wr wrap");
      burst(1'b1, 25'h1100, "rr rd");
      burst(1'b0, 25'h1080, "rr wr");
      burst(1'b1, 25'h1180, "rr rd wrap");
      chk("rr fill", 32'(fill), 32'd256);

      usedw = 10'd0;
      wrusedw = 10'd900;
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         step();
         if (rd_req) seen++;
      end
      chk("wt 124 free no rd", 32'(seen), 32'd0);
      wrusedw = 10'd896;
      burst(1'b1, 25'h1000, "wt 128 free rd");
      chk("fill 128", 32'(fill), 32'd128);

      usedw = 10'd1000;
      wrusedw = 10'd1023;
      wait_req(1'b0, "abort wr");
      chk("abort wr addr", 32'(wr_addr), 32'h1100);
      rd_fin = 1'b1;
      step();
      rd_fin = 1'b0;
      chk("stray rd_fin in WR", 32'(wr_req), 32'd1);
      chk("stray rd_fin fill", 32'(fill), 32'd128);
      init = 1'b0;
      step();
      chk("abort req low", 32'(wr_req), 32'd0);
      chk("abort fill", 32'(fill), 32'd0);
      usedw = 10'd0;
      init = 1'b1;
      step();
      wr_fin = 1'b1;
      step();
      wr_fin = 1'b0;
      chk("stray wr_fin idle fill", 32'(fill), 32'd0);
      chk("stray wr_fin idle req", 32'(wr_req), 32'd0);
      usedw = 10'd1000;
      burst(1'b0, 25'h1000, "restart wr");
      chk("restart fill", 32'(fill), 32'd128);

      init = 1'b0;
      full = 1'b1;
      step();
      full = 1'b0;
      chk("full w/o init", 32'(ovf), 32'd0);
      init = 1'b1;
      full = 1'b1;
      step();
      full = 1'b0;
      chk("ovf set", 32'(ovf), 32'd1);
      init = 1'b0;
      step();
      step();
      chk("ovf through init loss", 32'(ovf), 32'd1);
      init = 1'b1;
      step();
      chk("ovf after init", 32'(ovf), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("ovf async clear", 32'(ovf), 32'd0);
      chk("reset fill", 32'(fill), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ddr_burst_sched.md
Name: ddr_burst_sched

Overview:
- Burst scheduler sitting directly upstream of the DDR2 controller's burst user interface, in the controller's phy clock domain.
- Watches the AD→DDR FIFO fill level and the DDR→wavelet FIFO free space.
- Issues fixed-length write and read bursts against a ring buffer region in DDR.
- Tracks ring pointers and fill so the wavelet path receives samples in order, with no overrun of the ring.

Parameters:
- DATA_WIDTH, 32, data word width (informational; no data passes through this block)
- ADDR_WIDTH, 25, DDR word address width
- BURST_LEN, 128, words per burst; 1..512
- RING_WORDS, 4096, ring size in words; must be a multiple of BURST_LEN
- BASE_ADDR, 0, first word address of the ring
- FIFO_AW, 10, width of FIFO usedw counters
- WT_FIFO_DEPTH, 1024, depth of the wavelet FIFO

Ports:
- mem_clk  in  1  controller phy clock
- rst_n  in  1  asynchronous active-low reset
- local_init_done  in  1  DDR calibration done
- ad_fifo_usedw  in  FIFO_AW  words available in the AD→DDR FIFO
- ad_fifo_full  in  1  AD FIFO full flag
- wt_fifo_wrusedw  in  FIFO_AW  words occupied in the wavelet FIFO
- wr_burst_req  out  1  write burst request
- wr_burst_len  out  10  write length, constant BURST_LEN
- wr_burst_addr  out  ADDR_WIDTH  write start address
- wr_burst_finish  in  1  one-cycle write-done pulse
- rd_burst_req  out  1  read burst request
- rd_burst_len  out  10  read length, constant BURST_LEN
- rd_burst_addr  out  ADDR_WIDTH  read start address
- rd_burst_finish  in  1  one-cycle read-done pulse
- ring_fill  out  ADDR_WIDTH  words written to the ring and not yet read
- overflow  out  1  sticky AD FIFO overflow flag

Behaviour:
- Clocking and reset: single clock mem_clk; rst_n is asynchronous and active-low.
- Reset values: all outputs 0 except wr_burst_len and rd_burst_len, which are always BURST_LEN. Internal wptr=0, rptr=0, fill=0, last_grant=RD, state=IDLE.
- States: IDLE, WR, RD.
- Write eligibility (we): ad_fifo_usedw >= BURST_LEN AND fill <= RING_WORDS-BURST_LEN.
- Read eligibility (re): fill >= BURST_LEN AND (WT_FIFO_DEPTH - wt_fifo_wrusedw) >= BURST_LEN.
- IDLE, local_init_done=1: evaluate we/re.
  - Both true: grant the opposite of last_grant (round-robin).
  - One true: grant that one.
  - Grant registered: state→WR or RD, req high on the next edge, last_grant updated.
- Addresses:
  - wr_burst_addr = BASE_ADDR + wptr; rd_burst_addr = BASE_ADDR + rptr.
  - Registered at grant; stable for the whole burst.
- WR state: wr_burst_req held high until wr_burst_finish is sampled. On that edge:
  - req→0
  - wptr += BURST_LEN; wraps to 0 when it reaches RING_WORDS
  - fill += BURST_LEN
  - state→IDLE
- RD state: symmetric on rd_burst_finish; rptr advances with the same wrap, fill -= BURST_LEN.
- Pacing:
  - Only one burst is outstanding, so write and read fill updates never coincide.
  - At least one IDLE cycle separates bursts: req low for at least 1 cycle between consecutive bursts.
- Finish pulses: a finish not matching the current state (e.g. rd_burst_finish in WR or IDLE) is ignored.
- Calibration loss: local_init_done=0 in any state forces the following on the next edge:
  - state→IDLE, both reqs→0
  - wptr=rptr=fill=0 (ring contents considered lost)
  - last_grant=RD
  - overflow is not cleared
- Overflow: overflow sets on any cycle with ad_fifo_full=1 while local_init_done=1; it clears only on reset.
- ring_fill: equals fill, registered.
- Ring bounds: fill never exceeds RING_WORDS and never underflows; the eligibility rules guarantee this.

Decomposition:
- Shared package ddr_pkg holds:
  - state encoding (IDLE/WR/RD)
  - grant enum (GRANT_WR/GRANT_RD)
  - BURST_LEN_MAX=512 constant
- Sub-module ring_ptr (pointer register with parameterised increment and wrap), instantiated twice for wptr and rptr.
- The FSM and fill counter stay in the top module.

Test Plan (BURST_LEN=128, RING_WORDS=512, WT_FIFO_DEPTH=1024, BASE_ADDR=0x1000):
- Reset/init: local_init_done=0, ad_fifo_usedw=200 → no req. Raise init_done → wr_burst_req high 2 cycles later, wr_burst_addr=0x1000, len=128.
- Write then read: finish the write, ad_fifo_usedw=0, wt_fifo_wrusedw=0 → ring_fill=128, then rd_burst_req with rd_burst_addr=0x1000. After finish, ring_fill=0.
- Ring full: 4 writes with no reads → wr addrs 0x1000/0x1080/0x1100/0x1180, ring_fill=512. A 5th write is not issued despite ad_fifo_usedw=1000.
- Round-robin and wrap:
  - Both eligible → grants alternate WR,RD,WR,RD.
  - After 4 writes, the 5th write address wraps to 0x1000.
  - Wavelet FIFO at wrusedw=900 → no read issued (124 free).
- Abort: drop local_init_done mid-WR → req low next cycle, ring_fill=0. A subsequent write restarts at 0x1000; a stray wr_burst_finish while IDLE is ignored.
- Overflow: pulse ad_fifo_full for 1 cycle → overflow=1 and stays 1 through init_done toggling until rst_n low.
